posit_dot_seq: RTL and testbench
================================

# posit_dot_seq

Sequential dot-product controller for the posit FMA datapath. It accepts a stream of posit operand pairs over a valid/ready handshake and drives the combinational FMA with `IN1=a`, `IN2=b`, `IN3=running accumulator`. It captures `OUT` back into the accumulator and presents the final sum over a result handshake. The block sits directly upstream of the FMA and also consumes its output; the FMA instance stays outside this block and is wired in by the enclosing wrapper.

## Interface
- `N`, 32, posit width
- `ES`, 2, exponent field width; passed through for consistency with the FMA, with no arithmetic use here
- `LEN_W`, 8, width of the vector-length field
- `clk`  in  1  single clock, all state on the rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a new dot product; sampled only in IDLE
- `vec_len`  in  LEN_W  number of pairs; sampled with `start`
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept a pair
- `in_a`, `in_b`  in  N  posit operands
- `fma_in1`, `fma_in2`, `fma_in3`  out  N  to FMA `IN1`/`IN2`/`IN3`
- `fma_out`  in  N  from FMA `OUT`
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts result
- `result`  out  N  final accumulator value
- `busy`  out  1  state ≠ IDLE

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Registers:** `op_a`, `op_b`, `op_vld`, `acc`, `cnt` (LEN_W).
- **Combinational outputs:**
  - `fma_in1=op_a`, `fma_in2=op_b`, `fma_in3=acc`
  - `result=acc`
  - `in_ready = (state==RUN)`
  - `res_valid = (state==DONE)`
- **IDLE:**
  - `start` with `vec_len==0`: `acc<=0`, go to DONE.
  - `start` with `vec_len>0`: `acc<=0`, `cnt<=vec_len`, go to RUN.
  - `start` in any other state is ignored.
- **Every edge:**
  - If `op_vld`: `acc<=fma_out`.
  - `op_vld <= (in_valid && in_ready)`.
  - On accept: `op_a<=in_a`, `op_b<=in_b`.
- **RUN:**
  - Each accept decrements `cnt`.
  - Accept with `cnt==1` goes to DRAIN.
  - `in_valid` low leaves state and `cnt` unchanged; gaps are legal.
- **DRAIN:** the pending `op_vld` accumulation lands; go to DONE unconditionally.
- **DONE:** hold `acc`. When `res_valid && res_ready`, go to IDLE. `acc` keeps its value until the next `start`.
- **Arithmetic:**
  - All posit arithmetic, including rounding and NaR/zero handling, is the FMA's.
  - NaR (`1<<(N-1)`) propagates naturally because the FMA returns NaR with any NaR input.
  - Posit zero is all-zeros.
- **Reset:** all outputs and registers go to zero; state goes to IDLE. An operation in progress is discarded, and no result is produced for it.

## Timing
- **Reset values:** `in_ready=0`, `res_valid=0`, `busy=0`, `result=0`, `fma_in*=0`.
- **Start:** `start` at edge t puts the block in RUN from t+1; `in_ready` is high during cycle t+1.
- **Throughput:** one pair per cycle when `in_valid` is held high. The accumulator dependency is met because the pair at edge e is accumulated at edge e+1, at the same time as the pair at edge e+1 is loaded.
- **Latency:** last pair accepted at edge e → DRAIN during e..e+1 → `acc` final and `res_valid=1` from edge e+1.
- **Full-rate total:** `start` at t with L pairs gives `res_valid` high after edge t+L+1.
- **`vec_len==0`:** `res_valid` after edge t+1, with `result=0`.
- **Result hold:** `result` is stable while `res_valid && !res_ready`. IDLE is reached one edge after the handshake.
- **Timing path:** the critical path is `op_a`/`op_b`/`acc` → FMA → `acc`, in a single cycle.

## Structure
- **Package `posit_dot_pkg`:**
  - state enum `dot_state_t` {IDLE, RUN, DRAIN, DONE}
  - functions `posit_zero(N)` and `posit_nar(N)`, or the equivalent parameterised constants
- **Sub-modules:** none. The FSM and registers form one module; the FMA is instantiated by the wrapper.

## Test plan
- N=32, ES=2, L=2, pairs (0x40000000,0x48000000), (0x40000000,0x50000000) back-to-back → `result=0x54000000` (6.0), `res_valid` 3 edges after `start`.
- L=0 `start` → `res_valid` next cycle, `result=0x00000000`, `in_ready` never high.
- L=3 with `in_valid` gaps of 2 cycles between pairs, all (0x40000000,0x40000000) → `result=0x4C000000` (3.0). `cnt` must not decrement during gaps.
- L=2 with one operand 0x80000000 → `result=0x80000000`.
- `res_ready` held low 5 cycles → `result` and `res_valid` stable. `start` during DONE is ignored. After the handshake, `busy=0`.
- `reset` asserted in RUN after 1 of 4 pairs → next cycle state=IDLE, all outputs 0. A fresh L=1 (0x48000000,0x48000000) yields 0x50000000 (4.0).

Source files
------------

// File: rtl/posit_dot_pkg.sv
// Shared types and constants for the posit dot-product sequencer.
// The FMA datapath itself lives outside; only control-side definitions are here.
package posit_dot_pkg;

    localparam int POSIT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dot_state_t;

    function automatic logic [POSIT_MAX_W-1:0] posit_zero(input int n);
        logic [POSIT_MAX_W-1:0] z;
        z = '0;
        for (int i = 0; i < POSIT_MAX_W; i++) begin
            if (i >= n) z[i] = 1'b0;
        end
        return z;
    endfunction

    function automatic logic [POSIT_MAX_W-1:0] posit_nar(input int n);
        return POSIT_MAX_W'(1) << (n - 1);
    endfunction

    // Width must leave room for sign, a two-bit regime and the exponent field.
    function automatic bit posit_cfg_ok(input int n, input int es);
        return (es >= 0) && (n >= es + 3) && (n <= POSIT_MAX_W);
    endfunction

endpackage

// File: rtl/posit_dot_seq.sv
// Dot-product sequencer: streams operand pairs into an external posit FMA and
// folds its output back into a running accumulator, one pair per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; acc holds the last result
// RUN   | accepting pairs, cnt counts pairs still to come
// DRAIN | last pair is in op_a/op_b; its product lands in acc this edge
// DONE  | result presented; leaves on res_valid && res_ready
module posit_dot_seq
    import posit_dot_pkg::*;
#(
    parameter int N     = 32,
    parameter int ES    = 2,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [N-1:0]     fma_in1,
    output logic [N-1:0]     fma_in2,
    output logic [N-1:0]     fma_in3,
    input  logic [N-1:0]     fma_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     result,
    output logic             busy
);

    localparam logic [N-1:0] ZERO = N'(posit_zero(N));

    if (!posit_cfg_ok(N, ES)) begin : g_bad_cfg
        $error("posit_dot_seq: unsupported N/ES combination");
    end

    dot_state_t       state;
    dot_state_t       state_nxt;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             op_vld;
    logic [N-1:0]     acc;
    logic [LEN_W-1:0] cnt;

    logic accept;
    logic start_idle;
    logic last_pair;

    assign in_ready   = (state == RUN);
    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign start_idle = (state == IDLE) && start;
    assign last_pair  = (cnt == LEN_W'(1));

    assign fma_in1 = op_a;
    assign fma_in2 = op_b;
    assign fma_in3 = acc;
    assign result  = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (vec_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_pair) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // op_vld marks that op_a/op_b hold a pair whose FMA output is still to
    // be folded into acc; this pipelines accumulate behind the operand load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_a   <= ZERO;
            op_b   <= ZERO;
            op_vld <= 1'b0;
            acc    <= ZERO;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            op_vld <= accept;

            if (accept) begin
                op_a <= in_a;
                op_b <= in_b;
            end

            if (start_idle) begin
                acc <= ZERO;
            end else if (op_vld) begin
                acc <= fma_out;
            end

            if (start_idle) begin
                cnt <= vec_len;
            end else if (accept) begin
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_posit_dot_seq.sv
// Directed bench for posit_dot_seq with a behavioural posit32/es=2 FMA in the loop.
module tb_posit_dot_seq;

    localparam int N     = 32;
    localparam int ES    = 2;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N-1:0]     fma_in1;
    logic [N-1:0]     fma_in2;
    logic [N-1:0]     fma_in3;
    logic [N-1:0]     fma_out;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     result;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    posit_dot_seq #(.N(N), .ES(ES), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .fma_in1(fma_in1), .fma_in2(fma_in2), .fma_in3(fma_in3), .fma_out(fma_out),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural posit32 es=2 FMA ----------------
    function automatic real pow2(input int s);
        real r;
        r = 1.0;
        if (s >= 0) for (int i = 0; i < s; i++) r = r * 2.0;
        else        for (int i = 0; i < -s; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real p_dec(input logic [31:0] p);
        logic [31:0] x;
        logic        neg;
        logic        r0;
        int          m, idx, regime, e;
        real         f, w;
        if (p == 32'h0) return 0.0;
        neg = p[31];
        x   = neg ? (~p + 32'd1) : p;
        r0  = x[30];
        m   = 0;
        idx = 30;
        while (idx >= 0 && x[idx] == r0) begin
            m++;
            idx--;
        end
        regime = r0 ? (m - 1) : -m;
        idx--;
        e = 0;
        for (int k = 0; k < ES; k++) begin
            e = e * 2 + ((idx >= 0) ? int'(x[idx]) : 0);
            idx--;
        end
        f = 0.0;
        w = 0.5;
        while (idx >= 0) begin
            if (x[idx]) f = f + w;
            w = w / 2.0;
            idx--;
        end
        return (neg ? -1.0 : 1.0) * (1.0 + f) * pow2(4 * regime + e);
    endfunction

    function automatic logic [31:0] p_enc(input real v_in);
        logic [31:0] r;
        logic        neg;
        real         v, m, f;
        int          s, regime, e, pos;
        if (v_in == 0.0) return 32'h0;
        neg = (v_in < 0.0);
        v   = neg ? -v_in : v_in;
        m   = v;
        s   = 0;
        while (m >= 2.0) begin m = m / 2.0; s++; end
        while (m < 1.0)  begin m = m * 2.0; s--; end
        regime = (s >= 0) ? (s / 4) : -((-s + 3) / 4);
        e   = s - 4 * regime;
        f   = m - 1.0;
        r   = 32'h0;
        pos = 30;
        if (regime >= 0) begin
            for (int k = 0; k <= regime; k++) begin if (pos >= 0) r[pos] = 1'b1; pos--; end
            pos--;
        end else begin
            for (int k = 0; k < -regime; k++) pos--;
            if (pos >= 0) r[pos] = 1'b1;
            pos--;
        end
        for (int k = ES - 1; k >= 0; k--) begin
            if (pos >= 0) r[pos] = e[k];
            pos--;
        end
        while (pos >= 0) begin
            f = f * 2.0;
            if (f >= 1.0) begin r[pos] = 1'b1; f = f - 1.0; end
            pos--;
        end
        return neg ? (~r + 32'd1) : r;
    endfunction

    function automatic logic [31:0] fma_model(input logic [31:0] a, b, c);
        if (a == 32'h80000000 || b == 32'h80000000 || c == 32'h80000000) return 32'h80000000;
        return p_enc(p_dec(a) * p_dec(b) + p_dec(c));
    endfunction

    assign fma_out = fma_model(fma_in1, fma_in2, fma_in3);

    // ---------------- vectors ----------------
    typedef struct {
        string             name;
        int                len;
        logic [3:0][31:0]  a;
        logic [3:0][31:0]  b;
        int                gap;
        logic [31:0]       exp_res;
        int                exp_edges;
    } vec_t;

    function automatic vec_t mk(input string name, input int len,
                                input logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, input logic [31:0] exp_res, input int exp_edges);
        vec_t v;
        v.name = name;  v.len = len;  v.gap = gap;
        v.a[0] = a0;  v.b[0] = b0;  v.a[1] = a1;  v.b[1] = b1;
        v.a[2] = a2;  v.b[2] = b2;  v.a[3] = a3;  v.b[3] = b3;
        v.exp_res = exp_res;  v.exp_edges = exp_edges;
        return v;
    endfunction

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edges are counted from the start edge (edge 0) to the first edge after which res_valid is high.
    task automatic run_dot(input vec_t v, output logic [31:0] res, output int edges);
        start   = 1'b1;
        vec_len = LEN_W'(v.len);
        tick();
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick();
                    edges++;
                    check({v.name, " in_ready_gap"}, {31'b0, in_ready}, 32'd1);
                end
            end
            check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_a     = v.a[i];
            in_b     = v.b[i];
            tick();
            edges++;
            in_valid = 1'b0;
        end
        while (!res_valid && edges < 64) begin
            tick();
            edges++;
        end
        res = result;
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, " busy_after"}, {31'b0, busy}, 32'd0);
        check({name, " res_valid_after"}, {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        int          edges;
        vec_t        v;

        reset     = 1'b1;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("reset ctl", {29'b0, in_ready, res_valid, busy}, 32'd0);
        check("reset result", result, 32'h0);
        check("reset fma_in", fma_in1 | fma_in2 | fma_in3, 32'h0);
        reset = 1'b0;
        tick();

        tbl[0] = mk("basic", 2, 32'h40000000, 32'h48000000, 32'h40000000, 32'h50000000,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h54000000, 3);
        tbl[1] = mk("len0", 0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h00000000, 0);
        tbl[2] = mk("gaps", 3, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                    32'h40000000, 32'h40000000, 32'h0, 32'h0, 2, 32'h4C000000, 8);
        tbl[3] = mk("nar", 2, 32'h80000000, 32'h40000000, 32'h40000000, 32'h40000000,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h80000000, 3);
        tbl[4] = mk("len4", 4, 32'h48000000, 32'h48000000, 32'h40000000, 32'h48000000,
                    32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 0, 32'h58000000, 5);
        tbl[5] = mk("neg", 2, 32'h48000000, 32'h48000000, 32'hC0000000, 32'h40000000,
                    32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h4C000000, 3);

        for (int k = 0; k < 6; k++) begin
            run_dot(tbl[k], res, edges);
            if (tbl[k].len == 0) check({tbl[k].name, " in_ready_low"}, {31'b0, in_ready}, 32'd0);
            check({tbl[k].name, " latency"}, edges, tbl[k].exp_edges);
            check({tbl[k].name, " result"}, res, tbl[k].exp_res);
            check({tbl[k].name, " res_valid"}, {31'b0, res_valid}, 32'd1);
            check({tbl[k].name, " busy"}, {31'b0, busy}, 32'd1);
            handshake(tbl[k].name);
        end

        // Result hold under back-pressure, with a start pulse that must be ignored.
        v = mk("hold", 1, 32'h40000000, 32'h40000000, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h40000000, 2);
        run_dot(v, res, edges);
        check("hold latency", edges, 2);
        for (int j = 0; j < 5; j++) begin
            if (j == 2) begin
                start   = 1'b1;
                vec_len = 8'd3;
            end
            tick();
            start = 1'b0;
            check("hold result", result, 32'h40000000);
            check("hold state", {29'b0, res_valid, in_ready, busy}, 32'b101);
        end
        handshake("hold");

        // Reset mid-run discards the operation.
        start   = 1'b1;
        vec_len = 8'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 32'h48000000;
        in_b     = 32'h48000000;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrun acc", result, 32'h50000000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset ctl", {29'b0, in_ready, res_valid, busy}, 32'd0);
        check("midreset result", result, 32'h0);
        check("midreset fma_in", fma_in1 | fma_in2 | fma_in3, 32'h0);
        tick();
        v = mk("fresh", 1, 32'h48000000, 32'h48000000, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h50000000, 2);
        run_dot(v, res, edges);
        check("fresh latency", edges, 2);
        check("fresh result", res, 32'h50000000);
        handshake("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
